// File: rtl/rgb_entry_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : rgb_entry_ctrl
//  Purpose  : Keypad-driven three-digit decimal entry for the R, G and B
//             channel registers. Digits are mirrored right-aligned to the
//             7-segment path. Enter converts the entry to binary, checks
//             that it is in 0..255, commits it to the selected channel and
//             advances the channel R->G->B->R.
//  Ports    : clk        - system clock, rising edge
//             rst_n      - asynchronous active-low reset
//             key        - 0-9 digit, 10 Enter, 11 Clear, 12 Skip, 13-15 none
//             key_valid  - key strobe, sampled on each rising edge
//             u, d, c    - display digits (units, tens, hundreds), 16 = blank
//             chan       - selected channel (0=R, 1=G, 2=B)
//             r_val, g_val, b_val - committed channel values
//             load       - one-cycle pulse when a channel register updates
//             busy       - conversion/commit in progress, keys dropped
//             err        - entry error, cleared by the next key
//  Revision : 1.0 - initial release
// ============================================================================
module rgb_entry_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] key,
  input  logic       key_valid,
  output logic [4:0] u,
  output logic [4:0] d,
  output logic [4:0] c,
  output logic [1:0] chan,
  output logic [7:0] r_val,
  output logic [7:0] g_val,
  output logic [7:0] b_val,
  output logic       load,
  output logic       busy,
  output logic       err
);

  typedef enum logic [1:0] {
    ST_ENTRY  = 2'd0,
    ST_CALC   = 2'd1,
    ST_COMMIT = 2'd2,
    ST_ERROR  = 2'd3
  } state_t;

  localparam logic [4:0] BLANK     = 5'd16;
  localparam logic [3:0] KEY_ENTER = 4'd10;
  localparam logic [3:0] KEY_CLEAR = 4'd11;
  localparam logic [3:0] KEY_SKIP  = 4'd12;

  state_t     state_q, state_d;
  logic [4:0] u_q, u_d, d_q, d_d, c_q, c_d;
  logic [1:0] count_q, count_d;
  logic [1:0] chan_q, chan_d;
  logic [7:0] r_q, r_d, g_q, g_d, b_q, b_d;
  logic [9:0] val_q, val_d;
  logic       load_q, load_d;

  logic [3:0] u_bin, d_bin, c_bin;
  logic [9:0] calc_val;
  logic [1:0] chan_next;

  // Blank positions contribute zero to the decimal value.
  assign u_bin    = (u_q == BLANK) ? 4'd0 : u_q[3:0];
  assign d_bin    = (d_q == BLANK) ? 4'd0 : d_q[3:0];
  assign c_bin    = (c_q == BLANK) ? 4'd0 : c_q[3:0];
  assign calc_val = 10'(c_bin) * 10'd100 + 10'(d_bin) * 10'd10 + 10'(u_bin);

  assign chan_next = (chan_q == 2'd2) ? 2'd0 : chan_q + 2'd1;

  always_comb begin
    state_d = state_q;
    u_d     = u_q;
    d_d     = d_q;
    c_d     = c_q;
    count_d = count_q;
    chan_d  = chan_q;
    r_d     = r_q;
    g_d     = g_q;
    b_d     = b_q;
    val_d   = val_q;
    load_d  = 1'b0;

    case (state_q)
      ST_ENTRY: begin
        if (key_valid) begin
          if (key <= 4'd9) begin
            // A fourth digit is silently ignored.
            if (count_q != 2'd3) begin
              c_d     = d_q;
              d_d     = u_q;
              u_d     = {1'b0, key};
              count_d = count_q + 2'd1;
            end
          end else if (key == KEY_ENTER) begin
            state_d = (count_q == 2'd0) ? ST_ERROR : ST_CALC;
          end else if (key == KEY_CLEAR) begin
            u_d = BLANK; d_d = BLANK; c_d = BLANK;
            count_d = 2'd0;
          end else if (key == KEY_SKIP) begin
            chan_d = chan_next;
            u_d = BLANK; d_d = BLANK; c_d = BLANK;
            count_d = 2'd0;
          end
        end
      end

      ST_CALC: begin
        val_d   = calc_val;
        state_d = (calc_val > 10'd255) ? ST_ERROR : ST_COMMIT;
      end

      ST_COMMIT: begin
        // Range was already checked in CALC; the guard keeps a corrupted
        // value from ever reaching a channel register.
        if (val_q[9:8] == 2'b00) begin
          case (chan_q)
            2'd0:    r_d = val_q[7:0];
            2'd1:    g_d = val_q[7:0];
            default: b_d = val_q[7:0];
          endcase
          load_d = 1'b1;
        end
        chan_d  = chan_next;
        u_d = BLANK; d_d = BLANK; c_d = BLANK;
        count_d = 2'd0;
        state_d = ST_ENTRY;
      end

      default: begin  // ST_ERROR: the waking key is consumed, not decoded
        if (key_valid) begin
          u_d = BLANK; d_d = BLANK; c_d = BLANK;
          count_d = 2'd0;
          state_d = ST_ENTRY;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_ENTRY;
      u_q     <= BLANK;
      d_q     <= BLANK;
      c_q     <= BLANK;
      count_q <= 2'd0;
      chan_q  <= 2'd0;
      r_q     <= 8'd0;
      g_q     <= 8'd0;
      b_q     <= 8'd0;
      val_q   <= 10'd0;
      load_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      u_q     <= u_d;
      d_q     <= d_d;
      c_q     <= c_d;
      count_q <= count_d;
      chan_q  <= chan_d;
      r_q     <= r_d;
      g_q     <= g_d;
      b_q     <= b_d;
      val_q   <= val_d;
      load_q  <= load_d;
    end
  end

  assign u     = u_q;
  assign d     = d_q;
  assign c     = c_q;
  assign chan  = chan_q;
  assign r_val = r_q;
  assign g_val = g_q;
  assign b_val = b_q;
  assign load  = load_q;
  assign busy  = (state_q == ST_CALC) || (state_q == ST_COMMIT);
  assign err   = (state_q == ST_ERROR);

endmodule
`default_nettype wire

// File: tb/tb_rgb_entry_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rgb_entry_ctrl
//  Purpose  : Self-checking bench for rgb_entry_ctrl. A behavioural model
//             tracks the entered digits as a list, the pending conversion
//             and the channel values; every cycle all outputs are compared.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rgb_entry_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] key;
  logic       key_valid;
  logic [4:0] u, d, c;
  logic [1:0] chan;
  logic [7:0] r_val, g_val, b_val;
  logic       load, busy, err;

  rgb_entry_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key       (key),
    .key_valid (key_valid),
    .u         (u),
    .d         (d),
    .c         (c),
    .chan      (chan),
    .r_val     (r_val),
    .g_val     (g_val),
    .b_val     (b_val),
    .load      (load),
    .busy      (busy),
    .err       (err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // ---------------- reference model ----------------
  int m_dig[$];     // entered digits, oldest first
  int m_chan;
  int m_vals[3];
  bit m_err;
  int m_pend;       // cycles of conversion work remaining: 2 convert, 1 commit
  int m_val;
  bit m_load;

  task automatic model_reset();
    m_dig.delete();
    m_chan = 0;
    m_vals[0] = 0; m_vals[1] = 0; m_vals[2] = 0;
    m_err = 0; m_pend = 0; m_val = 0; m_load = 0;
  endtask

  task automatic model_step(input bit kv, input int k);
    m_load = 0;
    if (m_pend == 2) begin
      m_val = 0;
      foreach (m_dig[i]) m_val = m_val * 10 + m_dig[i];
      if (m_val > 255) begin m_err = 1; m_pend = 0; end
      else m_pend = 1;
    end else if (m_pend == 1) begin
      m_vals[m_chan] = m_val;
      m_load = 1;
      m_chan = (m_chan + 1) % 3;
      m_dig.delete();
      m_pend = 0;
    end else if (m_err) begin
      if (kv) begin m_err = 0; m_dig.delete(); end
    end else if (kv) begin
      if (k <= 9) begin
        if (m_dig.size() < 3) m_dig.push_back(k);
      end else if (k == 10) begin
        if (m_dig.size() == 0) m_err = 1;
        else m_pend = 2;
      end else if (k == 11) begin
        m_dig.delete();
      end else if (k == 12) begin
        m_chan = (m_chan + 1) % 3;
        m_dig.delete();
      end
    end
  endtask

  // pos 0 = units, 1 = tens, 2 = hundreds
  function automatic int disp(input int pos);
    int idx;
    idx = m_dig.size() - 1 - pos;
    return (idx >= 0) ? m_dig[idx] : 16;
  endfunction

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
  endtask

  task automatic check_outputs();
    check_eq("u",     int'(u),     disp(0));
    check_eq("d",     int'(d),     disp(1));
    check_eq("c",     int'(c),     disp(2));
    check_eq("chan",  int'(chan),  m_chan);
    check_eq("r_val", int'(r_val), m_vals[0]);
    check_eq("g_val", int'(g_val), m_vals[1]);
    check_eq("b_val", int'(b_val), m_vals[2]);
    check_eq("load",  int'(load),  int'(m_load));
    check_eq("busy",  int'(busy),  (m_pend != 0) ? 1 : 0);
    check_eq("err",   int'(err),   int'(m_err));
  endtask

  task automatic step(input bit kv, input int k);
    key_valid = kv;
    key       = 4'(k);
    @(posedge clk);
    model_step(kv, k);
    #1;
    check_outputs();
  endtask

  task automatic press(input int k);
    step(1'b1, k);
  endtask

  task automatic idle();
    step(1'b0, 0);
  endtask

  initial begin
    int r;
    int k;
    rst_n = 1'b0;
    key_valid = 1'b0;
    key = 4'd0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    #3 rst_n = 1'b1;

    // 128 into R
    press(1); press(2); press(8);
    check_eq("disp_c1", int'(c), 1);
    check_eq("disp_d2", int'(d), 2);
    check_eq("disp_u8", int'(u), 8);
    press(10);
    check_eq("busy_calc", int'(busy), 1);
    idle();
    idle();
    check_eq("r128", int'(r_val), 128);
    check_eq("load128", int'(load), 1);
    check_eq("chan_g", int'(chan), 1);
    idle();
    check_eq("load_once", int'(load), 0);

    // 256 on G -> out of range
    press(2); press(5); press(6); press(10);
    idle();
    check_eq("err256", int'(err), 1);
    check_eq("g_hold", int'(g_val), 0);
    press(5);   // consumed by the error recovery
    check_eq("err_clr", int'(err), 0);
    check_eq("u_blank", int'(u), 16);
    idle();

    // skip to B, enter 7, wrap to R
    press(12);
    press(7); press(10); idle(); idle();
    check_eq("b7", int'(b_val), 7);
    check_eq("chan_wrap", int'(chan), 0);

    // empty Enter -> error after one clock
    press(10);
    check_eq("err_empty", int'(err), 1);
    press(3);

    // fourth digit ignored, Clear, Skip
    press(9); press(9); press(9); press(4);
    check_eq("u9", int'(u), 9);
    check_eq("c9", int'(c), 9);
    press(11);
    press(12);
    check_eq("skip_noload", int'(load), 0);
    press(12); press(12);

    // 255 into R with a dropped strobe during CALC
    press(2); press(5); press(5); press(10);
    press(7);
    idle();
    check_eq("r255", int'(r_val), 255);
    check_eq("u_blank2", int'(u), 16);

    // reset asserted mid-COMMIT
    press(1); press(2); press(10);
    idle();
    check_eq("in_commit", int'(busy), 1);
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    key_valid = 1'b0;
    @(posedge clk);
    #1;
    check_outputs();
    #3 rst_n = 1'b1;

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      r = $urandom_range(0, 99);
      if (r < 55)      k = $urandom_range(0, 9);
      else if (r < 75) k = 10;
      else if (r < 82) k = 11;
      else if (r < 88) k = 12;
      else             k = $urandom_range(13, 15);
      step(($urandom_range(0, 1) == 1), k);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
